// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with one-shot and auto-reload modes and a registered terminal-count pulse.
// Optional prescaler enabled by defining DOWN_CNT_PRESCALE_EN (PRESCALE enabled cycles per decrement).
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;
    logic             r_busy;
    logic             w_step;

`ifdef DOWN_CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] r_pre;

    assign w_step = (r_pre == PW'(PRESCALE - 1));

    // Prescaler only advances on enabled RUN cycles and restarts on every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
        end else if (load) begin
            r_pre <= '0;
        end else if (r_state == RUN && en) begin
            if (w_step) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end
`else
    logic [8:0] w_unused_prescale;

    assign w_unused_prescale = 9'(PRESCALE);
    assign w_step            = 1'b1;
`endif

    // Priority load > en > hold; tc defaults low so it can never stretch past one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_tc     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_count  <= load_val;
                r_reload <= load_val;
                if (load_val != '0) begin
                    r_state <= RUN;
                    r_busy  <= 1'b1;
                end else begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end else if (r_state == RUN && en && w_step) begin
                if (r_count > WIDTH'(1)) begin
                    r_count <= r_count - 1'b1;
                end else if (mode) begin
                    r_count <= r_reload;
                    r_tc    <= 1'b1;
                end else begin
                    r_count <= '0;
                    r_tc    <= 1'b1;
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign busy  = r_busy;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed self-checking bench for down_counter_timer (WIDTH=4, PRESCALE=4).
// The prescaler scenario runs instead of the main scenarios when DOWN_CNT_PRESCALE_EN is defined.
module tb_down_counter_timer;

    logic       clk;
    logic       resetN;
    logic       loadIn;
    logic [3:0] loadVal;
    logic       enIn;
    logic       modeIn;
    logic [3:0] countOut;
    logic       tcOut;
    logic       busyOut;

    int compareCount  = 0;
    int mismatchCount = 0;

    down_counter_timer #(
        .WIDTH    (4),
        .PRESCALE (4)
    ) dut (
        .clk      (clk),
        .reset    (resetN),
        .load     (loadIn),
        .load_val (loadVal),
        .en       (enIn),
        .mode     (modeIn),
        .count    (countOut),
        .tc       (tcOut),
        .busy     (busyOut)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here so the counters stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then let it be clocked in and settle 1 ns past the edge.
    task automatic applyStimulus(input logic ld, input logic [3:0] lv, input logic e, input logic m);
        loadIn  = ld;
        loadVal = lv;
        enIn    = e;
        modeIn  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input int expCount, input int expTc, input int expBusy);
        checkOutput({tag, ".count"}, 32'(countOut), 32'(expCount));
        checkOutput({tag, ".tc"},    32'(tcOut),    32'(expTc));
        checkOutput({tag, ".busy"},  32'(busyOut),  32'(expBusy));
    endtask

    initial begin
        resetN  = 1'b0;
        loadIn  = 1'b0;
        loadVal = '0;
        enIn    = 1'b0;
        modeIn  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0);
        resetN = 1'b1;

`ifdef DOWN_CNT_PRESCALE_EN
        // Prescaler: decrement only every 4th enabled cycle.
        applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
        checkAll("pre.load", 2, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 4'd2, 1'b1, 1'b0);
            checkAll($sformatf("pre.c%0d", i), 2 - (i / 4), (i == 8) ? 1 : 0, (i == 8) ? 0 : 1);
        end
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkAll("pre.after", 0, 0, 0);
`else
        // Asynchronous reset in the middle of a count.
        applyStimulus(1'b1, 4'd8, 1'b1, 1'b0);
        checkAll("rst.load", 8, 0, 1);
        repeat (3) applyStimulus(1'b0, 4'd8, 1'b1, 1'b0);
        checkAll("rst.pre", 5, 0, 1);
        #2;
        resetN = 1'b0;
        #1;
        checkAll("rst.async", 0, 0, 0);
        resetN = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkAll("rst.en0", 0, 0, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkAll("rst.en1", 0, 0, 0);

        // One-shot: 3,2,1,0 with a single tc pulse as count reaches 0.
        begin
            int expC[5] = '{3, 2, 1, 0, 0};
            int expT[5] = '{0, 0, 0, 1, 0};
            int expB[5] = '{1, 1, 1, 0, 0};
            for (int i = 0; i < 5; i++) begin
                applyStimulus((i == 0), 4'd3, 1'b1, 1'b0);
                checkAll($sformatf("oneshot.%0d", i), expC[i], expT[i], expB[i]);
            end
        end

        // Auto-reload with load_val=2.
        begin
            int expC[7] = '{2, 1, 2, 1, 2, 1, 2};
            int expT[7] = '{0, 0, 1, 0, 1, 0, 1};
            for (int i = 0; i < 7; i++) begin
                applyStimulus((i == 0), 4'd2, 1'b1, 1'b1);
                checkAll($sformatf("reload.%0d", i), expC[i], expT[i], 1);
            end
        end

        // Enable gating, then load winning over enable.
        applyStimulus(1'b1, 4'd4, 1'b0, 1'b0);
        checkAll("gate.load", 4, 0, 1);
        begin
            logic enSeq[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
            int   expC[4]  = '{3, 3, 2, 1};
            for (int i = 0; i < 4; i++) begin
                applyStimulus(1'b0, 4'd4, enSeq[i], 1'b0);
                checkAll($sformatf("gate.%0d", i), expC[i], 0, 1);
            end
        end
        applyStimulus(1'b1, 4'd9, 1'b1, 1'b0);
        checkAll("gate.reload9", 9, 0, 1);

        // load_val=0 goes straight to IDLE without tc.
        applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
        checkAll("zero.load", 0, 0, 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 1'b0);
        checkAll("zero.hold", 0, 0, 0);

        // Full-scale one-shot: tc exactly 15 enabled cycles after load.
        applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
        checkAll("max.load", 15, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 4'd15, 1'b1, 1'b0);
            checkAll($sformatf("max.%0d", i), 15 - i, (i == 15) ? 1 : 0, (i == 15) ? 0 : 1);
        end
        applyStimulus(1'b0, 4'd15, 1'b1, 1'b0);
        checkAll("max.after", 0, 0, 0);

        // Reload value 1: tc on every enabled cycle, never stretched across en=0.
        applyStimulus(1'b1, 4'd1, 1'b0, 1'b1);
        checkAll("one.load", 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 4'd1, 1'b1, 1'b1);
            checkAll($sformatf("one.%0d", i), 1, 1, 1);
        end
        applyStimulus(1'b0, 4'd1, 1'b0, 1'b1);
        checkAll("one.gap", 1, 0, 1);
        applyStimulus(1'b0, 4'd1, 1'b1, 1'b1);
        checkAll("one.resume", 1, 1, 1);

        // Switching to one-shot terminates the periodic count.
        applyStimulus(1'b0, 4'd1, 1'b1, 1'b0);
        checkAll("one.stop", 0, 1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
